// File: rtl/riscv_run_ctrl_if.sv
// Run-controller bundle: the run-control requests and core observations going in,
// plus the core reset/enable, status, cause flags and counters coming out.
// No timing or backpressure of its own. It is a plain signal bundle.
//
// Ports (as seen by the controller, slave side):
//   in : start, abort, step_mode, step_req, pc[PC_W], instr_retired
//   out: core_rst, core_en, running, done, halted, timeout, aborted,
//        cycle_cnt[CNT_W], retire_cnt[CNT_W]
interface riscv_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  // run control and core observation, driven by bench / debug logic
  logic             start;
  logic             abort;
  logic             step_mode;
  logic             step_req;
  logic [PC_W-1:0]  pc;
  logic             instr_retired;

  // controller outputs
  logic             core_rst;
  logic             core_en;
  logic             running;
  logic             done;
  logic             halted;
  logic             timeout;
  logic             aborted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;

  // side that requests runs and watches the result
  modport master (
    output start, abort, step_mode, step_req, pc, instr_retired,
    input  core_rst, core_en, running, done, halted, timeout, aborted,
           cycle_cnt, retire_cnt
  );

  // the run controller itself
  modport slave (
    input  start, abort, step_mode, step_req, pc, instr_retired,
    output core_rst, core_en, running, done, halted, timeout, aborted,
           cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/riscv_run_ctrl.sv
// Run controller for the RV32I core: sequences core reset and enable, single-step, and stop on halt/timeout/abort.
// All outputs are registered. Start-to-first-enable takes RST_CYCLES+1 edges, and every stop cause reaches done in one edge.
// No backpressure. Inputs are sampled every edge. In step mode one rising edge of step_req grants exactly one enabled cycle.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high controller reset, overrides all other inputs
//   bus  : riscv_run_ctrl_if slave modport
//          in : start, abort, step_mode, step_req, pc, instr_retired
//          out: core_rst, core_en, running, done, halted/timeout/aborted (sticky),
//               cycle_cnt, retire_cnt (saturating, cleared by start)
module riscv_run_ctrl #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1024,
  parameter int HALT_REPEAT = 4,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  riscv_run_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // reset-phase edge counter: RESET lasts until it has counted RST_CYCLES edges
  localparam int             RC_W    = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES);

  // repeat counter counts matches, so HALT_REPEAT identical PCs means HALT_REPEAT-1 matches
  localparam int               REP_W    = $clog2(HALT_REPEAT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

  localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // state
  logic [1:0]       state;
  logic [RC_W-1:0]  rst_cnt;
  logic             step_req_d;
  logic [PC_W-1:0]  pc_hist;
  logic             hist_vld;
  logic [REP_W-1:0] rep_cnt;

  // registered outputs
  logic             core_rst_q;
  logic             core_en_q;
  logic             running_q;
  logic             done_q;
  logic             halted_q;
  logic             timeout_q;
  logic             aborted_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;

  // combinational
  logic             step_edge;
  logic             en_req;
  logic             pc_match;
  logic             halt_hit;
  logic             tout_hit;
  logic [REP_W-1:0] rep_nxt;
  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] ret_nxt;
  logic [1:0]       state_nxt;
  logic             en_nxt;
  logic             clr_run;
  logic             set_abort;
  logic             set_halt;
  logic             set_tout;

  // A level held high on step_req grants a single step. Only the 0->1 transition counts.
  assign step_edge = bus.step_req & ~step_req_d;

  // Enable wanted for the next cycle if the run continues. step_mode is sampled here,
  // so a mode change affects the cycle after the edge that sees it.
  assign en_req = bus.step_mode ? step_edge : 1'b1;

  // The first enabled cycle of a run has no predecessor to compare against.
  assign pc_match = hist_vld && (bus.pc == pc_hist);

  // Per-enabled-cycle bookkeeping. core_en_q is the enable of the cycle now ending.
  always_comb begin
    rep_nxt = rep_cnt;
    cyc_nxt = cycle_cnt_q;
    ret_nxt = retire_cnt_q;
    if (core_en_q) begin
      if (pc_match) begin
        if (rep_cnt != REP_LAST) begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end else begin
        rep_nxt = '0;
      end
      if (cycle_cnt_q != CNT_SAT) begin
        cyc_nxt = cycle_cnt_q + 1'b1;
      end
      if (bus.instr_retired && (retire_cnt_q != CNT_SAT)) begin
        ret_nxt = retire_cnt_q + 1'b1;
      end
    end
  end

  assign halt_hit = core_en_q && pc_match && (rep_nxt == REP_LAST);
  assign tout_hit = core_en_q && (cyc_nxt == CYC_MAX);

  // Next state. Each stop branch sets exactly one cause, in the order abort > halt > timeout.
  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    clr_run   = 1'b0;
    set_abort = 1'b0;
    set_halt  = 1'b0;
    set_tout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.abort) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else if (bus.start) begin
          state_nxt = S_RESET;
          clr_run   = 1'b1;
        end
      end
      S_RESET: begin
        if (bus.abort) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else if (rst_cnt == RC_LAST) begin
          state_nxt = S_RUN;
          en_nxt    = en_req;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else if (halt_hit) begin
          state_nxt = S_DONE;
          set_halt  = 1'b1;
        end else if (tout_hit) begin
          state_nxt = S_DONE;
          set_tout  = 1'b1;
        end else begin
          en_nxt = en_req;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_nxt = S_RESET;
          clr_run   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      step_req_d   <= 1'b0;
      pc_hist      <= '0;
      hist_vld     <= 1'b0;
      rep_cnt      <= '0;
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state      <= state_nxt;
      step_req_d <= bus.step_req;

      // status outputs follow the state being entered so they line up with it
      core_rst_q <= (state_nxt == S_IDLE) || (state_nxt == S_RESET);
      core_en_q  <= en_nxt;
      running_q  <= (state_nxt == S_RUN);
      done_q     <= (state_nxt == S_DONE);

      if (clr_run) begin
        rst_cnt <= '0;
      end else if ((state == S_RESET) && (rst_cnt != RC_LAST)) begin
        rst_cnt <= rst_cnt + 1'b1;
      end

      if (clr_run) begin
        pc_hist      <= '0;
        hist_vld     <= 1'b0;
        rep_cnt      <= '0;
        cycle_cnt_q  <= '0;
        retire_cnt_q <= '0;
        halted_q     <= 1'b0;
        timeout_q    <= 1'b0;
        aborted_q    <= 1'b0;
      end else begin
        // the next-values equal the current ones on disabled cycles, so history is frozen then
        cycle_cnt_q  <= cyc_nxt;
        retire_cnt_q <= ret_nxt;
        rep_cnt      <= rep_nxt;
        if (core_en_q) begin
          pc_hist  <= bus.pc;
          hist_vld <= 1'b1;
        end
        if (set_abort) aborted_q <= 1'b1;
        if (set_halt)  halted_q  <= 1'b1;
        if (set_tout)  timeout_q <= 1'b1;
      end
    end
  end

  assign bus.core_rst   = core_rst_q;
  assign bus.core_en    = core_en_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.halted     = halted_q;
  assign bus.timeout    = timeout_q;
  assign bus.aborted    = aborted_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: directed run scenarios followed by randomized control traffic.
// Every output is compared each cycle against a behavioural model of the run rules.
// The model derives the reset window from edge numbers and detects halt from a queue of enabled-cycle PCs.
module tb_riscv_run_ctrl;
  localparam int RST_C   = 2;
  localparam int MAX_C   = 8;
  localparam int HR      = 4;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus();

  riscv_run_ctrl #(
    .RST_CYCLES (RST_C),
    .MAX_CYCLES (MAX_C),
    .HALT_REPEAT(HR),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RESET, M_RUN, M_DONE} mph_t;
  mph_t            m_ph = M_IDLE;
  int              m_edge = 0;
  int              m_run_edge = 0;   // edge number on which RUN is entered
  int              m_cyc = 0;
  int              m_ret = 0;
  bit              m_en = 1'b0;      // expected enable for the cycle after the current edge
  bit              m_prev_step = 1'b0;
  bit              m_h = 1'b0;
  bit              m_t = 1'b0;
  bit              m_a = 1'b0;
  logic [PC_W-1:0] m_pcs[$];         // PCs of every enabled cycle this run

  function automatic bit m_halt_seen();
    int n;
    n = m_pcs.size();
    if (n < HR) return 1'b0;
    for (int i = 1; i < HR; i++) begin
      if (m_pcs[n-1-i] != m_pcs[n-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_new_run();
    m_ph       = M_RESET;
    m_run_edge = m_edge + RST_C + 1;
    m_cyc      = 0;
    m_ret      = 0;
    m_h        = 1'b0;
    m_t        = 1'b0;
    m_a        = 1'b0;
    m_pcs.delete();
  endtask

  task automatic model_step();
    bit en_was, rise, halt, tout;
    m_edge++;
    en_was      = m_en;
    rise        = bus.step_req && !m_prev_step;
    m_prev_step = bus.step_req;
    m_en        = 1'b0;
    if (rst) begin
      m_ph        = M_IDLE;
      m_prev_step = 1'b0;
      m_cyc       = 0;
      m_ret       = 0;
      m_h         = 1'b0;
      m_t         = 1'b0;
      m_a         = 1'b0;
      m_pcs.delete();
      return;
    end
    case (m_ph)
      M_IDLE: begin
        if (bus.abort) begin m_ph = M_DONE; m_a = 1'b1; end
        else if (bus.start) m_new_run();
      end
      M_RESET: begin
        if (bus.abort) begin m_ph = M_DONE; m_a = 1'b1; end
        else if (m_edge == m_run_edge) begin
          m_ph = M_RUN;
          m_en = bus.step_mode ? rise : 1'b1;
        end
      end
      M_RUN: begin
        if (en_was) begin
          if (m_cyc < CNT_MAX) m_cyc++;
          if (bus.instr_retired && m_ret < CNT_MAX) m_ret++;
          m_pcs.push_back(bus.pc);
        end
        halt = en_was && m_halt_seen();
        tout = en_was && (m_cyc == MAX_C);
        if (bus.abort)  begin m_ph = M_DONE; m_a = 1'b1; end
        else if (halt)  begin m_ph = M_DONE; m_h = 1'b1; end
        else if (tout)  begin m_ph = M_DONE; m_t = 1'b1; end
        else m_en = bus.step_mode ? rise : 1'b1;
      end
      M_DONE: begin
        if (bus.start) m_new_run();
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("core_rst",   bus.core_rst,   (m_ph == M_IDLE) || (m_ph == M_RESET));
    chk("core_en",    bus.core_en,    m_en);
    chk("running",    bus.running,    m_ph == M_RUN);
    chk("done",       bus.done,       m_ph == M_DONE);
    chk("halted",     bus.halted,     m_h);
    chk("timeout",    bus.timeout,    m_t);
    chk("aborted",    bus.aborted,    m_a);
    chk("cycle_cnt",  bus.cycle_cnt,  m_cyc);
    chk("retire_cnt", bus.retire_cnt, m_ret);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------- directed helpers ----------------
  logic [31:0] pc_seq[$];

  task automatic set_seq_inc(input int n, input int base);
    pc_seq.delete();
    for (int i = 0; i < n; i++) pc_seq.push_back(32'(base + 4 * i));
  endtask

  // pulse start, then count the cycles core_rst stays high afterwards
  task automatic start_run(output int rst_hi);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst_hi = 0;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus.core_rst) rst_hi++;
      else break;
    end
  endtask

  // drive pc_seq onto each enabled cycle. Optionally raise abort on the Nth one or stop after N.
  task automatic run_seq(input int abort_at, input int stop_after, output int en_n);
    int n;
    n = 0;
    en_n = 0;
    while (!bus.done && n < 60 && (stop_after == 0 || en_n < stop_after)) begin
      if (bus.core_en) begin
        bus.pc = pc_seq[(en_n < pc_seq.size()) ? en_n : pc_seq.size() - 1];
        en_n++;
        if (en_n == abort_at) bus.abort = 1'b1;
      end
      tick();
      bus.abort = 1'b0;
      n++;
    end
    if (stop_after == 0) chk("run_reaches_done", bus.done, 1'b1);
  endtask

  task automatic step_pulse(input int hi, input int lo, inout int en_n);
    for (int i = 0; i < hi + lo; i++) begin
      bus.step_req = (i < hi);
      bus.pc = 32'(100 + 4 * en_n);
      tick();
      if (bus.core_en) en_n++;
    end
  endtask

  initial begin
    int rst_hi, en_n, en_b;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_req = 1'b0;
    bus.pc = '0;
    bus.instr_retired = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_core_rst", bus.core_rst, 1'b1);
    chk("rst_core_en", bus.core_en, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_cycle_cnt", bus.cycle_cnt, 0);
    rst = 1'b0;
    tick();

    // free-run to timeout with incrementing pc
    set_seq_inc(MAX_C, 0);
    start_run(rst_hi);
    chk("fr_rst_hi_cycles", rst_hi, RST_C);
    chk("fr_first_en", bus.core_en, 1'b1);
    chk("fr_first_running", bus.running, 1'b1);
    run_seq(0, 0, en_n);
    chk("fr_timeout", bus.timeout, 1'b1);
    chk("fr_halted", bus.halted, 1'b0);
    chk("fr_cycle_cnt", bus.cycle_cnt, MAX_C);
    chk("fr_en_cycles", en_n, MAX_C);

    // halt on pc 0,4,8,8,8,8 with every instruction retiring
    bus.instr_retired = 1'b1;
    pc_seq = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
    start_run(rst_hi);
    run_seq(0, 0, en_n);
    chk("halt_halted", bus.halted, 1'b1);
    chk("halt_timeout", bus.timeout, 1'b0);
    chk("halt_cycle_cnt", bus.cycle_cnt, 6);
    chk("halt_retire_cnt", bus.retire_cnt, 6);
    chk("halt_en_cycles", en_n, 6);
    bus.instr_retired = 1'b0;

    // single-step: three pulses, the middle one held for five cycles
    bus.step_mode = 1'b1;
    start_run(rst_hi);
    chk("step_idle_en", bus.core_en, 1'b0);
    en_n = 0;
    step_pulse(1, 3, en_n);
    step_pulse(5, 3, en_n);
    step_pulse(1, 3, en_n);
    chk("step_en_cycles", en_n, 3);
    chk("step_cycle_cnt", bus.cycle_cnt, 3);
    chk("step_running", bus.running, 1'b1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("step_abort_done", bus.done, 1'b1);
    chk("step_aborted", bus.aborted, 1'b1);
    bus.step_mode = 1'b0;

    // halt and timeout on the same edge: halt wins
    pc_seq = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd16, 32'd16, 32'd16};
    start_run(rst_hi);
    run_seq(0, 0, en_n);
    chk("ht_halted", bus.halted, 1'b1);
    chk("ht_timeout", bus.timeout, 1'b0);
    chk("ht_cycle_cnt", bus.cycle_cnt, 8);

    // abort and halt on the same edge: abort wins
    pc_seq = '{32'd40};
    start_run(rst_hi);
    run_seq(HR, 0, en_n);
    chk("ah_aborted", bus.aborted, 1'b1);
    chk("ah_halted", bus.halted, 1'b0);
    chk("ah_cycle_cnt", bus.cycle_cnt, HR);

    // rst mid-run after five enabled cycles
    set_seq_inc(MAX_C, 0);
    start_run(rst_hi);
    run_seq(0, 5, en_n);
    chk("mr_cycle_before", bus.cycle_cnt, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_core_rst", bus.core_rst, 1'b1);
    chk("mr_core_en", bus.core_en, 1'b0);
    chk("mr_running", bus.running, 1'b0);
    chk("mr_cycle_cnt", bus.cycle_cnt, 0);
    chk("mr_retire_cnt", bus.retire_cnt, 0);
    chk("mr_flags", {bus.halted, bus.timeout, bus.aborted}, 3'b000);

    // timeout, then restart from DONE with a start pulse ignored mid-run
    start_run(rst_hi);
    run_seq(0, 0, en_n);
    chk("rs_first_timeout", bus.timeout, 1'b1);
    start_run(rst_hi);
    chk("rs_rst_hi_cycles", rst_hi, RST_C);
    chk("rs_cleared_cnt", bus.cycle_cnt, 0);
    chk("rs_cleared_timeout", bus.timeout, 1'b0);
    run_seq(0, 3, en_n);
    bus.start = 1'b1;
    bus.pc = 32'd200;
    tick();
    bus.start = 1'b0;
    chk("rs_start_ignored_run", bus.running, 1'b1);
    chk("rs_start_ignored_rst", bus.core_rst, 1'b0);
    run_seq(0, 0, en_b);
    chk("rs_timeout", bus.timeout, 1'b1);
    chk("rs_cycle_cnt", bus.cycle_cnt, MAX_C);
    chk("rs_tail_en", en_b, MAX_C - 4);

    // randomized control traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 14) == 0);
      bus.abort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 149) == 0) bus.step_mode = ~bus.step_mode;
      if ($urandom_range(0, 2) == 0) bus.step_req = ~bus.step_req;
      if ($urandom_range(0, 2) == 0) bus.pc = 32'($urandom_range(0, 3)) * 32'd4;
      bus.instr_retired = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Synthesizable run controller that sequences reset, clock-enable, single-step and end-of-test detection for the pipelined RV32I core (`Full_datapath`). It replaces hand-toggled clock/reset sequences: the core always runs on `clk`, while this block drives its reset and enable. It stops the run on one of three events: a self-loop halt (PC stuck), a cycle budget expiry, or an external abort. Counters it exposes let benches and FPGA debug logic check cycle and retire counts directly.

## Interface
- `RST_CYCLES`, 2: cycles `core_rst` is held after `start` (≥1)
- `MAX_CYCLES`, 1024: enabled-cycle budget before timeout (≥1, < 2^`CNT_W`)
- `HALT_REPEAT`, 4: consecutive enabled cycles with unchanged `pc` that declare halt (≥2)
- `PC_W`, 32: width of `pc`
- `CNT_W`, 16: width of both counters
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high controller reset
- `start`  in  1  begin a run (sampled in IDLE or DONE)
- `abort`  in  1  stop the current run
- `step_mode`  in  1  1 = single-step, 0 = free-run
- `step_req`  in  1  each rising edge grants one enabled cycle in step mode
- `pc`  in  `PC_W`  core fetch PC
- `instr_retired`  in  1  core write-back valid
- `core_rst`  out  1  reset to core
- `core_en`  out  1  clock enable to core
- `running`  out  1  state is RUN
- `done`  out  1  state is DONE
- `halted`, `timeout`, `aborted`  out  1 each  sticky cause flags, cleared by `start`
- `cycle_cnt`  out  `CNT_W`  enabled cycles this run
- `retire_cnt`  out  `CNT_W`  retired instructions this run

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- On `rst`: state is IDLE, with `core_rst`=1, `core_en`=0, `running`=0 and `done`=0. All flags are 0, counters are 0, and the step edge detector is cleared.
- IDLE:
  - `core_rst`=1.
  - `start` moves to RESET.
- RESET:
  - `core_rst`=1 for exactly `RST_CYCLES` cycles, then RUN.
  - On entry, counters, flags, the PC history and the repeat counter are cleared.
- RUN:
  - `core_rst`=0.
  - Free-run: `core_en`=1 every cycle.
  - Step mode: `core_en`=1 for exactly one cycle per detected rising edge of `step_req`; otherwise 0. A level held high grants one step only.
  - A `step_mode` change takes effect on the next cycle.
- On each cycle with `core_en`=1:
  - `cycle_cnt` increments.
  - `retire_cnt` increments if `instr_retired`.
  - `pc` is compared with the `pc` of the previous enabled cycle. On a match the repeat counter increments; on a mismatch it clears.
  - Disabled cycles neither advance nor clear the history.
- Exit conditions from RUN to DONE, evaluated on the same edge, with priority abort > halt > timeout:
  - `abort` → `aborted`=1.
  - Repeat counter reaches `HALT_REPEAT`-1 matches on an enabled cycle → `halted`=1.
  - `cycle_cnt` reaches `MAX_CYCLES` → `timeout`=1.
  - Only the highest-priority cause flag is set.
- DONE:
  - `core_en`=0 and `core_rst`=0, so core state is frozen but readable.
  - Counters and flags hold.
  - `start` moves to RESET.
- `abort` in IDLE or RESET goes to DONE with `aborted`=1; the core is never enabled.
- `start` in RUN or RESET is ignored.
- `rst` in any state, including mid-run, returns to IDLE on the next edge and overrides every other input.
- Counters saturate at 2^`CNT_W`-1.

## Timing
- `start` high at edge k (IDLE):
  - `core_rst` stays 1 through edge k+`RST_CYCLES`.
  - At edge k+`RST_CYCLES`+1: `core_rst`=0, `running`=1, and `core_en`=1 in free-run mode.
- Step: `step_req` rises, is sampled at edge j, and `core_en`=1 for the single cycle after edge j.
- Timeout: exactly `MAX_CYCLES` cycles have `core_en`=1. On the edge that counts the last one, `core_en` drops and `done` rises.
- Halt: on the edge that registers the `HALT_REPEAT`-th identical enabled-cycle `pc`, `core_en` drops and `done`/`halted` rise.
- Abort: one-edge latency to `done`. The enable during the cycle `abort` is sampled still counts.

## Test plan
- Free-run, RST_CYCLES=2, MAX_CYCLES=8, `pc` incrementing by 4 → `core_rst` high for 2 cycles after `start`; 8 enabled cycles; `timeout`=1, `cycle_cnt`=8, `halted`=0.
- `pc` sequence 0,4,8,8,8,8 with HALT_REPEAT=4 and `instr_retired`=1 throughout → `halted`=1 after the 6th enabled cycle, `cycle_cnt`=6, `retire_cnt`=6.
- Step mode, `step_req` pulsed 3 times (one pulse held 5 cycles) → exactly 3 `core_en` cycles, `cycle_cnt`=3, `running` stays 1.
- Halt and timeout on the same edge (MAX_CYCLES=4, `pc` constant, HALT_REPEAT=4) → `halted`=1, `timeout`=0; then `abort` and halt on the same edge in a new run → `aborted`=1 only.
- `rst` asserted mid-RUN after 5 cycles → next edge: IDLE, `core_rst`=1, `core_en`=0, counters 0, flags 0.
- `start` from DONE after a timeout → flags and counters cleared, reset sequence replayed, new run counts from 0; `start` pulsed during RUN has no effect.
